// File: rtl/cover_toggle_collector_if.sv
// Cover-event intake and hit-bitmap dump handshakes for cover_toggle_collector.
// master: event producer / dump consumer.  slave: the collector.
interface cover_toggle_collector_if;
  logic        ev_valid;
  logic [63:0] ev_index;
  logic        ev_ready;
  logic        dump_start;
  logic        dump_valid;
  logic [63:0] dump_index;
  logic        dump_ready;
  logic        dump_done;

  modport master (
    output ev_valid, ev_index, dump_start, dump_ready,
    input  ev_ready, dump_valid, dump_index, dump_done
  );

  modport slave (
    input  ev_valid, ev_index, dump_start, dump_ready,
    output ev_ready, dump_valid, dump_index, dump_done
  );
endinterface

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector: sticky hit bitmap for a window of NUM_POINTS global
// cover indices starting at COVER_INDEX, with a serial dump of hit points.
// Events are only accepted while idle; a dump walks the bitmap one bit per
// cycle and presents each hit point until the consumer takes it.
// Optional feature macro: COVER_CLEAR_ON_DUMP_EN -- a dumped point is cleared
// from the bitmap and hit_count, so a full dump leaves the collector empty.
module cover_toggle_collector #(
  parameter int unsigned NUM_POINTS  = 39,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 8940
) (
  input  logic                              clock,
  input  logic                              reset,
  cover_toggle_collector_if.slave           bus,
  output logic [$clog2(NUM_POINTS+1)-1:0]   hit_count,
  output logic [15:0]                       oor_count
);
  localparam int CW = $clog2(NUM_POINTS+1);
  localparam int PW = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_POINTS-1);
  localparam logic [63:0]   BASE = 64'(COVER_INDEX);

  // The local window has to sit inside the global cover space.
  if (COVER_INDEX + NUM_POINTS > COVER_TOTAL) begin : g_range_chk
    $error("cover window exceeds COVER_TOTAL");
  end

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

  state_t                state, state_nx;
  logic [NUM_POINTS-1:0] hit_map;
  logic [PW-1:0]         ptr;
  logic [63:0]           off;
  logic [PW-1:0]         off_idx;
  logic                  ev_acc, in_rng, new_hit, ptr_hit, dump_hs;

  assign ev_acc  = bus.ev_valid && bus.ev_ready;
  assign off     = bus.ev_index - BASE;
  assign in_rng  = (bus.ev_index >= BASE) && (off < 64'(NUM_POINTS));
  assign off_idx = off[PW-1:0];
  assign new_hit = ev_acc && in_rng && !hit_map[off_idx];
  assign ptr_hit = hit_map[ptr];
  assign dump_hs = (state == HOLD) && bus.dump_ready;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: walk the bitmap, park in HOLD on every hit bit.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.dump_start) state_nx = SCAN;
      SCAN: begin
        if (ptr_hit)           state_nx = HOLD;
        else if (ptr == LAST)  state_nx = DONE;
      end
      HOLD: begin
        if (bus.dump_ready)    state_nx = (ptr == LAST) ? DONE : SCAN;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; dump_valid is a state-register bit in HOLD.
  always_comb begin
    bus.ev_ready   = (state == IDLE);
    bus.dump_valid = (state == HOLD);
    bus.dump_done  = (state == DONE);
  end

  // Scan pointer and the registered global index of the point being offered.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr            <= '0;
      bus.dump_index <= '0;
    end else begin
      case (state)
        IDLE: if (bus.dump_start) ptr <= '0;
        SCAN: begin
          if (ptr_hit)            bus.dump_index <= BASE + 64'(ptr);
          else if (ptr != LAST)   ptr <= ptr + PW'(1);
        end
        HOLD: if (bus.dump_ready && ptr != LAST) ptr <= ptr + PW'(1);
        default: ;
      endcase
    end
  end

  // Sticky hit bitmap, distinct-hit count and saturating out-of-range count.
  // Events only land in IDLE and dump handshakes only in HOLD, so the two
  // update sources never collide on the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_map   <= '0;
      hit_count <= '0;
      oor_count <= '0;
    end else begin
      if (ev_acc && in_rng)                  hit_map[off_idx] <= 1'b1;
      if (new_hit)                           hit_count <= hit_count + CW'(1);
      if (ev_acc && !in_rng && oor_count != 16'hFFFF)
                                             oor_count <= oor_count + 16'd1;
`ifdef COVER_CLEAR_ON_DUMP_EN
      if (dump_hs) begin
        hit_map[ptr] <= 1'b0;
        hit_count    <= hit_count - CW'(1);
      end
`else
      if (dump_hs) hit_map[ptr] <= hit_map[ptr];
`endif
    end
  end
endmodule

// File: tb/tb_cover_toggle_collector.sv
// Randomized + directed bench for cover_toggle_collector against a set-based
// reference model of the cover window.
module tb_cover_toggle_collector;
  localparam int N  = 39;
  localparam int CW = $clog2(N+1);
`ifdef COVER_CLEAR_ON_DUMP_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cover_toggle_collector_if bus();
  cover_toggle_collector_if bus2();
  logic [CW-1:0] hit_count, hit_count2;
  logic [15:0]   oor_count, oor_count2;

  cover_toggle_collector #(.NUM_POINTS(N)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .hit_count(hit_count), .oor_count(oor_count)
  );

  cover_toggle_collector #(.NUM_POINTS(N), .COVER_INDEX(100)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2),
    .hit_count(hit_count2), .oor_count(oor_count2)
  );

  // reference model: set of hit points plus counters
  bit mh[N];
  int mcnt, moor;
  int checks = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < N; i++) mh[i] = 1'b0;
    mcnt = 0; moor = 0;
  endtask

  task automatic mdl_ev(input logic [63:0] idx);
    if (idx < 64'(N)) begin
      if (!mh[int'(idx)]) mcnt++;
      mh[int'(idx)] = 1'b1;
    end else if (moor < 65535) moor++;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    mdl_clear();
  endtask

  task automatic send_ev(input logic [63:0] idx);
    bus.ev_valid = 1'b1; bus.ev_index = idx;
    chk("ev_ready_idle", 64'(bus.ev_ready), 64'd1);
    tick();
    mdl_ev(idx);
    bus.ev_valid = 1'b0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_hit_count"}, 64'(hit_count), 64'(mcnt));
    chk({tag, "_oor_count"}, 64'(oor_count), 64'(moor));
  endtask

  // Full dump: compares every offered index with the model's hit set in
  // ascending order, the done cycle and the ready/done framing.
  task automatic run_dump(input bit rnd, input int hold_low, input bit with_ev,
                          input logic [63:0] ev_idx, output int first_vc);
    int  exp_q[$];
    int  k, vc, vtot, cyc;
    bit  rdy;
    bus.dump_start = 1'b1;
    if (with_ev) begin bus.ev_valid = 1'b1; bus.ev_index = ev_idx; end
    chk("ev_ready_pre_dump", 64'(bus.ev_ready), 64'd1);
    tick();
    if (with_ev) mdl_ev(ev_idx);
    bus.dump_start = 1'b0; bus.ev_valid = 1'b0;
    for (int i = 0; i < N; i++) if (mh[i]) exp_q.push_back(i);
    k = 0; vc = 0; vtot = 0; cyc = 1; first_vc = 0;
    while (cyc <= 4*N + 200 && !bus.dump_done) begin
      chk("ev_ready_busy", 64'(bus.ev_ready), 64'd0);
      if (bus.dump_valid) begin
        vc++; vtot++;
        chk("dump_index", bus.dump_index, (k < exp_q.size()) ? 64'(exp_q[k]) : 64'hFFFF_FFFF_FFFF_FFFF);
        rdy = rnd ? ($urandom_range(0, 1) == 1 || vc > 3) : (vc > hold_low);
        bus.dump_ready = rdy;
        if (rdy) begin
          if (k == 0) first_vc = vc;
          k++; vc = 0;
        end
      end else begin
        bus.dump_ready = 1'($urandom_range(0, 1));
      end
      // a stray dump_start mid-scan must be ignored
      bus.dump_start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      cyc++;
    end
    bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
    chk("dump_done_seen", 64'(bus.dump_done), 64'd1);
    chk("dump_entries", 64'(k), 64'(exp_q.size()));
    chk("dump_done_cycle", 64'(cyc), 64'(N + 1 + vtot));
    chk("ev_ready_in_done", 64'(bus.ev_ready), 64'd0);
    chk("dump_valid_in_done", 64'(bus.dump_valid), 64'd0);
    tick();
    chk("dump_done_one_pulse", 64'(bus.dump_done), 64'd0);
    chk("ev_ready_after_done", 64'(bus.ev_ready), 64'd1);
    if (CLR) begin
      for (int i = 0; i < N; i++) mh[i] = 1'b0;
      mcnt = 0;
    end
  endtask

  task automatic send2(input logic [63:0] idx);
    bus2.ev_valid = 1'b1; bus2.ev_index = idx;
    tick();
    bus2.ev_valid = 1'b0;
  endtask

  initial begin
    int fv;
    logic [63:0] idx;
    bus.ev_valid = 0; bus.ev_index = 0; bus.dump_start = 0; bus.dump_ready = 0;
    bus2.ev_valid = 0; bus2.ev_index = 0; bus2.dump_start = 0; bus2.dump_ready = 0;
    reset = 1'b1;
    tick();
    do_reset();

    // reset state
    chk("rst_hit_count", 64'(hit_count), 64'd0);
    chk("rst_oor_count", 64'(oor_count), 64'd0);
    chk("rst_dump_valid", 64'(bus.dump_valid), 64'd0);
    chk("rst_dump_done", 64'(bus.dump_done), 64'd0);
    chk("rst_dump_index", bus.dump_index, 64'd0);
    chk("rst_ev_ready", 64'(bus.ev_ready), 64'd1);

    // empty dump: done at N+1 with no entries
    run_dump(1'b0, 0, 1'b0, 64'd0, fv);

    // events 3, 3, 38
    send_ev(64'd3); send_ev(64'd3); send_ev(64'd38);
    chk("rep_hit_count", 64'(hit_count), 64'd2);
    chk("rep_oor_count", 64'(oor_count), 64'd0);
    chk_counts("rep");
    run_dump(1'b0, 0, 1'b0, 64'd0, fv);

    // offset window: 99 and 139 are outside [100,139)
    send2(64'd99); send2(64'd139);
    chk("win_oor_count", 64'(oor_count2), 64'd2);
    chk("win_hit_count", 64'(hit_count2), 64'd0);
    send2(64'd100); send2(64'd138); send2(64'd100);
    chk("win_edge_hit_count", 64'(hit_count2), 64'd2);
    chk("win_edge_oor_count", 64'(oor_count2), 64'd2);

    // hits 0, 5 with consumer stalling 4 cycles on the first entry
    do_reset();
    send_ev(64'd0); send_ev(64'd5);
    run_dump(1'b0, 4, 1'b0, 64'd0, fv);
    chk("hold_stall_cycles", 64'(fv), 64'd5);
    chk_counts("stall");

    // event accepted in the dump_start cycle is part of the scan
    do_reset();
    run_dump(1'b0, 0, 1'b1, 64'd7, fv);
    chk("same_cycle_ev_len", 64'(fv), 64'd1);
    chk_counts("same_cycle");

    // reset while holding an entry
    do_reset();
    send_ev(64'd10); send_ev(64'd20);
    bus.dump_start = 1'b1; tick(); bus.dump_start = 1'b0;
    for (int i = 0; i < 2*N && !bus.dump_valid; i++) tick();
    chk("hold_reached", 64'(bus.dump_valid), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    mdl_clear();
    chk("rst_hold_dump_valid", 64'(bus.dump_valid), 64'd0);
    chk("rst_hold_hit_count", 64'(hit_count), 64'd0);
    chk("rst_hold_ev_ready", 64'(bus.ev_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_hold_no_done", 64'(bus.dump_done), 64'd0);
      tick();
    end

    // hits 1, 2; two back-to-back dumps
    do_reset();
    send_ev(64'd1); send_ev(64'd2);
    run_dump(1'b0, 0, 1'b0, 64'd0, fv);
    chk_counts("dump1");
    run_dump(1'b0, 0, 1'b0, 64'd0, fv);
    chk_counts("dump2");

    // randomized traffic with random consumer backpressure
    do_reset();
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(5, 40));
      for (int e = 0; e < n; e++) begin
        if ($urandom_range(0, 3) == 0) idx = {$urandom, $urandom} | 64'h40;
        else                           idx = 64'($urandom_range(0, N-1));
        send_ev(idx);
        if ($urandom_range(0, 2) == 0) tick();
      end
      chk_counts("rnd");
      run_dump(1'b1, 0, 1'($urandom_range(0, 1)), 64'($urandom_range(0, N-1)), fv);
      chk_counts("rnd_post");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
